// File: rtl/ip_sdram_arbiter_pkg.sv
// Shared constants for the two-port SDRAM arbiter: default parameters and FSM encodings.
package ip_sdram_arbiter_pkg;

  localparam int DEF_ADDR_W    = 23;
  localparam int DEF_TIMEOUT   = 64;
  localparam int DEF_MAX_A_RUN = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam logic [15:0] RDATA_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/ip_sdram_arbiter.sv
// Two-port (VDP / debugger) front end for ip_sdram: one access in flight,
// A-priority with a bounded A run while B waits, read timeout returning 16'hFFFF.
module ip_sdram_arbiter
  import ip_sdram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int MAX_A_RUN = DEF_MAX_A_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              sdram_rd_n,
  output logic              sdram_wr_n,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [7:0]        sdram_wdata,
  input  logic              sdram_busy,
  input  logic [15:0]       sdram_rdata,
  input  logic              sdram_rdata_en
);

  localparam int RUN_W = $clog2(MAX_A_RUN + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_A_RUN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [RUN_W-1:0] a_run;
  logic [TMO_W-1:0] tmo_cnt;
  logic             gnt_b;
  logic             gnt_wr;
  logic             grant;
  logic             pick_b;
  logic             pick_wr;
  logic             rd_done;
  logic [15:0]      done_data;

  always_comb begin
    grant     = ~sdram_busy & (a_req | b_req);
    pick_b    = b_req & (~a_req | (a_run >= RUN_MAX));
    pick_wr   = pick_b ? b_wr : a_wr;
    // Data arriving on the last timeout cycle still completes normally.
    rd_done   = (state == ST_WAIT_RD) & (sdram_rdata_en | (tmo_cnt == TMO_LAST));
    done_data = sdram_rdata_en ? sdram_rdata : RDATA_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      sdram_rd_n    <= 1'b1;
      sdram_wr_n    <= 1'b1;
      sdram_address <= '0;
      sdram_wdata   <= '0;
      a_ack         <= 1'b0;
      b_ack         <= 1'b0;
      a_rdata       <= '0;
      b_rdata       <= '0;
      a_run         <= '0;
      tmo_cnt       <= '0;
      gnt_b         <= 1'b0;
      gnt_wr        <= 1'b0;
    end else begin
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      sdram_rd_n <= 1'b1;
      sdram_wr_n <= 1'b1;
      if (!b_req) a_run <= '0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            gnt_b         <= pick_b;
            gnt_wr        <= pick_wr;
            sdram_address <= pick_b ? b_address : a_address;
            sdram_wdata   <= pick_b ? b_wdata : a_wdata;
            if (pick_wr) sdram_wr_n <= 1'b0;
            else         sdram_rd_n <= 1'b0;
            if (pick_b)                        a_run <= '0;
            else if (b_req && a_run != RUN_MAX) a_run <= a_run + 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (gnt_wr) begin
            a_ack <= ~gnt_b;
            b_ack <= gnt_b;
            state <= ST_GAP;
          end else begin
            tmo_cnt <= '0;
            state   <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (rd_done) begin
            if (gnt_b) begin
              b_ack   <= 1'b1;
              b_rdata <= done_data;
            end else begin
              a_ack   <= 1'b1;
              a_rdata <= done_data;
            end
            state <= ST_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ip_sdram_arbiter.md
IP_SDRAM_ARBITER -- requirements
Module: ip_sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, 23, SDRAM byte-address width (matches ip_sdram address).
REQ-002 Parameter TIMEOUT, 64, cycles allowed from read strobe to sdram_rdata_en before abort.
REQ-003 Parameter MAX_A_RUN, 4, consecutive port-A grants allowed while port B is pending.
REQ-004 clk  in  1  single system clock (108 MHz domain); all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 a_req, a_wr  in  1 each  port A (VDP) request level and write(1)/read(0) select.
REQ-007 a_address  in  ADDR_W, a_wdata  in  8  port A address and write byte.
REQ-008 a_ack  out  1  port A completion pulse; a_rdata  out  16  read data, valid when a_ack.
REQ-009 b_req, b_wr, b_address, b_wdata, b_ack, b_rdata  port B (debugger/CPU side), same widths and meaning as port A.
REQ-010 sdram_rd_n, sdram_wr_n  out  1 each  active-low one-cycle command strobes to ip_sdram.
REQ-011 sdram_address  out  ADDR_W, sdram_wdata  out  8  registered command operands.
REQ-012 sdram_busy  in  1, sdram_rdata  in  16, sdram_rdata_en  in  1  ip_sdram status and read return.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT_RD, GAP; exactly one request in flight.
REQ-014 IDLE: if sdram_busy=0 and any req, grant, latch address/wdata/wr of the granted port, go ISSUE; else stay.
REQ-015 Priority: A over B, except when B pending and A has taken MAX_A_RUN consecutive grants -> B granted.
REQ-016 Run counter: increments on each A grant while b_req=1, clears on any B grant or when b_req=0; saturates at MAX_A_RUN.
REQ-017 ISSUE: exactly one cycle with sdram_rd_n=0 (read) or sdram_wr_n=0 (write); operands stable in that cycle.
REQ-018 Write: ack of granted port pulses the cycle after ISSUE, then GAP. Latency req->strobe 1 cycle, req->ack 2 cycles.
REQ-019 Read: ISSUE -> WAIT_RD; on sdram_rdata_en=1 capture sdram_rdata, pulse granted ack next cycle with that data, then GAP.
REQ-020 WAIT_RD timeout: TIMEOUT cycles without sdram_rdata_en -> ack pulse with rdata=16'hFFFF, then GAP.
REQ-021 sdram_rdata_en in same cycle as timeout expiry: data wins, normal completion.
REQ-022 sdram_rdata_en outside WAIT_RD is ignored; a_rdata/b_rdata hold last value otherwise.
REQ-023 GAP: one cycle, no grant, so requester may drop req after ack without double service; -> IDLE.
REQ-024 ack is a single-cycle pulse, never on both ports at once; ungranted port's ack stays 0.
REQ-025 req dropped before ack: in-flight access completes, ack still pulses once.
REQ-026 sdram_busy high in ISSUE/WAIT_RD has no effect; only sampled in IDLE (covers post-reset init busy).

Reset
REQ-027 On reset=1: state IDLE, sdram_rd_n=sdram_wr_n=1, a_ack=b_ack=0, a_rdata=b_rdata=0, run and timeout counters 0, operands 0.
REQ-028 Reset mid-operation aborts the access without ack; first grant possible the cycle after reset deasserts (if sdram_busy=0).

Structure
REQ-029 State encodings and default parameter values reside in shared package/header ip_sdram_arbiter_pkg.
REQ-030 Single flat module; no sub-module; outputs registered; ~200 RTL lines.

Verification
REQ-031 After reset, sdram_busy=1 for 20 cycles with a_req=1 -> no strobe until busy falls; strobe 1 cycle later.
REQ-032 A write 0x000123<-0x5A -> sdram_wr_n low 1 cycle, address 0x000123, wdata 0x5A; a_ack 2 cycles after req.
REQ-033 B read, model returns 0xBEEF 6 cycles after strobe -> b_ack 1 cycle after rdata_en, b_rdata=0xBEEF.
REQ-034 a_req, b_req held continuously, writes -> grant order A,A,A,A,B,A,A,A,A,B; no ack on both ports.
REQ-035 Read with no rdata_en -> ack after 64 cycles in WAIT_RD, rdata=0xFFFF; rdata_en on cycle 64 -> real data.
REQ-036 reset asserted in WAIT_RD -> strobes high, no ack; next request serviced normally.
